// File: rtl/user_proj_counter_bank_if.sv
// Wishbone classic slave bundle for the counter bank; the master side drives
// the request, the slave returns ack and registered read data.
interface user_proj_counter_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/user_proj_counter_bank.sv
// NUM_CH-channel Wishbone up/down counter bank with compare match, auto-reload,
// W1C status and a registered interrupt; channel 0 is mirrored to pads and LA.
module user_proj_counter_bank #(
  parameter int          NUM_CH  = 4,
  parameter int          WIDTH   = 16,
  parameter int          IO_BITS = 16,
  parameter logic [7:0]  ADDR_HI = 8'h30
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  user_proj_counter_bank_if.slave wbs,
  input  logic [127:0]         la_data_in,
  input  logic [127:0]         la_oenb,
  output logic [127:0]         la_data_out,
  input  logic [IO_BITS-1:0]   io_in,
  output logic [IO_BITS-1:0]   io_out,
  output logic [IO_BITS-1:0]   io_oeb,
  output logic [2:0]           irq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [31:0] ID_VAL = {8'hC0, 8'(NUM_CH), 8'(WIDTH), 8'h01};

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic              r_ack;
  logic [31:0]       r_dat;
  logic              r_irq;
  logic [3:0]        r_ctrl  [NUM_CH];
  logic [WIDTH-1:0]  r_count [NUM_CH];
  logic [WIDTH-1:0]  r_cmp   [NUM_CH];
  logic [NUM_CH-1:0] r_status;

  logic              w_sel;
  logic              w_acc;
  logic              w_wr;
  logic [3:0]        w_ch_idx;
  logic [1:0]        w_off;
  logic              w_ch_hit;
  logic              w_stat_hit;
  logic              w_id_hit;
  logic              w_la_clr;
  logic              w_la_frz;
  logic [31:0]       w_rdata;
  logic [31:0]       w_w1c;
  logic [NUM_CH-1:0] w_match;
  logic [NUM_CH-1:0] w_ien;
  logic [NUM_CH-1:0] w_wr_ch;
  logic [NUM_CH-1:0] w_status_nxt;
  logic [3:0]        w_ctrl_nxt  [NUM_CH];
  logic [WIDTH-1:0]  w_count_nxt [NUM_CH];
  logic [WIDTH-1:0]  w_cmp_nxt   [NUM_CH];
  logic              w_unused;

  // An access is accepted once per ack: the cycle ack is high never starts another.
  assign w_sel    = wbs.wbs_cyc_i && wbs.wbs_stb_i && (wbs.wbs_adr_i[31:24] == ADDR_HI);
  assign w_acc    = w_sel && !r_ack;
  assign w_wr     = w_acc && wbs.wbs_we_i;
  assign w_ch_idx = wbs.wbs_adr_i[7:4];
  assign w_off    = wbs.wbs_adr_i[3:2];

  assign w_ch_hit   = (wbs.wbs_adr_i[23:8] == 16'h0000) && ({1'b0, w_ch_idx} < 5'(NUM_CH));
  assign w_stat_hit = (wbs.wbs_adr_i[23:8] == 16'h0001) && (wbs.wbs_adr_i[7:2] == 6'd0);
  assign w_id_hit   = (wbs.wbs_adr_i[23:8] == 16'h0001) && (wbs.wbs_adr_i[7:2] == 6'd1);

  assign w_la_clr = !la_oenb[65] && la_data_in[65];
  assign w_la_frz = !la_oenb[64] && la_data_in[64];

  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch_hit && (w_ch_idx == 4'(n))) begin
        case (w_off)
          2'd0:    w_rdata = {28'd0, r_ctrl[n]};
          2'd1:    w_rdata = 32'(r_count[n]);
          2'd2:    w_rdata = 32'(r_cmp[n]);
          default: w_rdata = '0;
        endcase
      end
    end
    if (w_stat_hit) w_rdata = 32'(r_status);
    if (w_id_hit)   w_rdata = ID_VAL;
  end

  // Count priority: LA clear, bus write, freeze, disabled, reload on match, step.
  always_comb begin
    w_w1c   = (w_wr && w_stat_hit) ? byte_merge(32'd0, wbs.wbs_dat_i, wbs.wbs_sel_i) : 32'd0;
    w_match = '0;
    w_ien   = '0;
    w_wr_ch = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_ien[n]   = r_ctrl[n][2];
      w_match[n] = r_ctrl[n][0] &&
                   (r_ctrl[n][1] ? (r_count[n] == '0) : (r_count[n] == r_cmp[n]));
      w_wr_ch[n] = w_wr && w_ch_hit && (w_ch_idx == 4'(n));

      w_ctrl_nxt[n] = r_ctrl[n];
      if (w_wr_ch[n] && (w_off == 2'd0) && wbs.wbs_sel_i[0])
        w_ctrl_nxt[n] = wbs.wbs_dat_i[3:0];

      w_cmp_nxt[n] = r_cmp[n];
      if (w_wr_ch[n] && (w_off == 2'd2))
        w_cmp_nxt[n] = WIDTH'(byte_merge(32'(r_cmp[n]), wbs.wbs_dat_i, wbs.wbs_sel_i));

      if (w_la_clr)
        w_count_nxt[n] = '0;
      else if (w_wr_ch[n] && (w_off == 2'd1))
        w_count_nxt[n] = WIDTH'(byte_merge(32'(r_count[n]), wbs.wbs_dat_i, wbs.wbs_sel_i));
      else if (w_la_frz || !r_ctrl[n][0])
        w_count_nxt[n] = r_count[n];
      else if (w_match[n] && r_ctrl[n][3])
        w_count_nxt[n] = r_ctrl[n][1] ? r_cmp[n] : '0;
      else if (r_ctrl[n][1])
        w_count_nxt[n] = r_count[n] - ONE;
      else
        w_count_nxt[n] = r_count[n] + ONE;
    end
    w_status_nxt = (r_status & ~w_w1c[NUM_CH-1:0]) | w_match;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_irq    <= 1'b0;
      r_status <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_ctrl[n]  <= '0;
        r_count[n] <= '0;
        r_cmp[n]   <= '1;
      end
    end else begin
      r_ack    <= w_acc;
      r_dat    <= w_acc ? w_rdata : 32'd0;
      r_status <= w_status_nxt;
      r_irq    <= |(r_status & w_ien);
      for (int n = 0; n < NUM_CH; n++) begin
        r_ctrl[n]  <= w_ctrl_nxt[n];
        r_count[n] <= w_count_nxt[n];
        r_cmp[n]   <= w_cmp_nxt[n];
      end
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign irq           = {2'b00, r_irq};
  assign io_out        = IO_BITS'(r_count[0]);
  assign io_oeb        = {IO_BITS{wb_rst_i}};
  assign la_data_out   = {80'd0, 16'(r_status), 32'(r_count[0])};

  assign w_unused = &{1'b0, io_in, la_data_in[127:66], la_data_in[63:0],
                      la_oenb[127:66], la_oenb[63:0], wbs.wbs_adr_i[1:0]};

endmodule

// File: tb/tb_user_proj_counter_bank.sv
// Scoreboard bench for user_proj_counter_bank: expected read data is queued as
// each access is driven and popped when the ack returns.
module tb_user_proj_counter_bank;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] ID_EXP = 32'hC004_1001;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] laDataIn;
  logic [127:0] laOenb;
  logic [127:0] laDataOut;
  logic [15:0]  ioIn;
  logic [15:0]  ioOut;
  logic [15:0]  ioOeb;
  logic [2:0]   irq;

  int nVec  = 0;
  int nMiss = 0;
  int cyc   = 0;
  logic [31:0] qExp[$];

  user_proj_counter_bank_if wbs();

  user_proj_counter_bank dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (wbs),
    .la_data_in  (laDataIn),
    .la_oenb     (laOenb),
    .la_data_out (laDataOut),
    .io_in       (ioIn),
    .io_out      (ioOut),
    .io_oeb      (ioOeb),
    .irq         (irq)
  );

  // Free-running clock and edge counter used to predict counter values.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop if the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one Wishbone access starting now; wait at most 16 edges for ack,
  // then release the bus and idle one edge so the next access starts clean.
  task automatic applyStimulus(input logic [31:0] adr, input logic we,
                               input logic [31:0] dat, input logic [3:0] sel,
                               output logic [31:0] rd, output logic acked,
                               output int ackCyc);
    rd = '0;
    acked = 1'b0;
    ackCyc = -1;
    wbs.wbs_adr_i = adr;
    wbs.wbs_we_i  = we;
    wbs.wbs_dat_i = dat;
    wbs.wbs_sel_i = sel;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (wbs.wbs_ack_o) begin
        acked  = 1'b1;
        rd     = wbs.wbs_dat_o;
        ackCyc = cyc;
        break;
      end
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int ackCyc);
    logic [31:0] rd;
    logic ok;
    applyStimulus(adr, 1'b1, dat, sel, rd, ok, ackCyc);
  endtask

  // Reset values, ID read latency, foreign address, unmapped and default reads.
  task automatic test_reset();
    logic [31:0] rd, e;
    logic ok;
    int ac, startCyc;
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    rst = 1'b1;
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'h0; wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0;
    laOenb = '1; laDataIn = '0; ioIn = '0;
    repeat (3) @(posedge clk);
    #1;
    nVec++;
    if (wbs.wbs_ack_o !== 1'b0 || wbs.wbs_dat_o !== 32'd0 || irq !== 3'd0) begin
      nMiss++;
      $display("[TB] FAIL reset_bus: got ack=%b dat=%h irq=%b, want 0/0/0", wbs.wbs_ack_o, wbs.wbs_dat_o, irq);
    end
    nVec++;
    if (ioOeb !== 16'hFFFF) begin
      nMiss++;
      $display("[TB] FAIL reset_oeb: got %h, want ffff", ioOeb);
    end
    nVec++;
    if (laDataOut !== 128'd0 || ioOut !== 16'd0) begin
      nMiss++;
      $display("[TB] FAIL reset_mirror: got la=%h io=%h, want 0/0", laDataOut, ioOut);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    nVec++;
    if (ioOeb !== 16'h0000) begin
      nMiss++;
      $display("[TB] FAIL run_oeb: got %h, want 0000", ioOeb);
    end

    startCyc = cyc;
    qExp.push_back(ID_EXP);
    applyStimulus(BASE + 32'h104, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e || ac != startCyc + 1) begin
      nMiss++;
      $display("[TB] FAIL id_read: got %h ack=%b lat=%0d, want %h lat=1", rd, ok, ac - startCyc, e);
    end

    applyStimulus(32'h3100_0000, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    nVec++;
    if (ok !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL foreign_addr: got ack=%b, want no ack", ok);
    end

    adrs = '{BASE + 32'h008, BASE + 32'h100, BASE + 32'h0F0, BASE + 32'h00C};
    exps = '{32'h0000_FFFF, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      qExp.push_back(exps[i]);
      applyStimulus(adrs[i], 1'b0, 32'd0, 4'hF, rd, ok, ac);
      e = qExp.pop_front();
      nVec++;
      if (!ok || rd !== e) begin
        nMiss++;
        $display("[TB] FAIL default_read[%0h]: got %h ack=%b, want %h", adrs[i], rd, ok, e);
      end
    end
  endtask

  // Channel 1 up-count with auto-reload at 5, status, irq and W1C.
  task automatic test_auto_reload();
    logic [31:0] rd, e;
    logic ok;
    logic expIrq;
    int ac, w, a, rise;
    wbWrite(BASE + 32'h018, 32'd5, 4'hF, ac);
    wbWrite(BASE + 32'h010, 32'hD, 4'hF, w);
    for (int i = 0; i < 10; i++) begin
      expIrq = (cyc >= w + 7);
      nVec++;
      if (irq !== {2'b00, expIrq}) begin
        nMiss++;
        $display("[TB] FAIL irq_first_match@%0d: got %b, want %b", cyc - w, irq, {2'b00, expIrq});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        @(posedge clk); #1;
      end
      qExp.push_back(32'((cyc - w) % 6));
      applyStimulus(BASE + 32'h014, 1'b0, 32'd0, 4'hF, rd, ok, ac);
      e = qExp.pop_front();
      nVec++;
      if (!ok || rd !== e) begin
        nMiss++;
        $display("[TB] FAIL count1_seq[%0d]: got %h, want %h", i, rd, e);
      end
    end
    qExp.push_back(32'h2);
    applyStimulus(BASE + 32'h100, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL status_ch1: got %h, want %h", rd, e);
    end
    for (int i = 0; i < 12; i++) begin
      if ((cyc - w) % 6 == 0) break;
      @(posedge clk); #1;
    end
    wbWrite(BASE + 32'h100, 32'h2, 4'hF, a);
    nVec++;
    if (irq !== 3'd0) begin
      nMiss++;
      $display("[TB] FAIL irq_after_w1c: got %b, want 000", irq);
    end
    rise = -1;
    for (int i = 0; i < 12; i++) begin
      if (irq[0]) begin
        rise = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    nVec++;
    if (rise != a + 6) begin
      nMiss++;
      $display("[TB] FAIL irq_reassert: got edge %0d after ack, want 6", rise - a);
    end
    wbWrite(BASE + 32'h010, 32'h0, 4'hF, ac);
    wbWrite(BASE + 32'h100, 32'hF, 4'hF, ac);
  endtask

  // Channel 0 down-count with reload to CMP, mirrored on io_out and LA.
  task automatic test_down_reload();
    logic [15:0] seq [4];
    logic [15:0] e;
    int ac, w;
    seq = '{16'd3, 16'd2, 16'd1, 16'd0};
    wbWrite(BASE + 32'h008, 32'd3, 4'hF, ac);
    wbWrite(BASE + 32'h004, 32'd3, 4'hF, ac);
    wbWrite(BASE + 32'h000, 32'hB, 4'hF, w);
    for (int i = 0; i < 10; i++) begin
      e = seq[(cyc - w) % 4];
      nVec++;
      if (ioOut !== e || laDataOut[31:0] !== {16'd0, e}) begin
        nMiss++;
        $display("[TB] FAIL down_seq[%0d]: got io=%h la=%h, want %h", i, ioOut, laDataOut[31:0], e);
      end
      @(posedge clk); #1;
    end
    nVec++;
    if (laDataOut[47:32] !== 16'h0001 || laDataOut[127:48] !== 80'd0) begin
      nMiss++;
      $display("[TB] FAIL la_status: got %h, want 0001 with zero upper bits", laDataOut[127:32]);
    end
    wbWrite(BASE + 32'h000, 32'h0, 4'hF, ac);
    wbWrite(BASE + 32'h100, 32'hF, 4'hF, ac);
  endtask

  // Wrap from 0xFFFF and byte-lane writes to COUNT.
  task automatic test_wrap_and_bytes();
    logic [31:0] rd, e;
    logic [15:0] ee;
    logic ok;
    int ac, w, d;
    wbWrite(BASE + 32'h008, 32'h10, 4'hF, ac);
    wbWrite(BASE + 32'h004, 32'hFFFF, 4'hF, ac);
    qExp.push_back(32'h0000_FFFF);
    applyStimulus(BASE + 32'h004, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL count0_preload: got %h, want %h", rd, e);
    end
    wbWrite(BASE + 32'h000, 32'h1, 4'hF, w);
    for (int i = 0; i < 3; i++) begin
      ee = 16'(32'hFFFF + cyc - w);
      nVec++;
      if (ioOut !== ee) begin
        nMiss++;
        $display("[TB] FAIL wrap[%0d]: got %h, want %h", i, ioOut, ee);
      end
      @(posedge clk); #1;
    end
    wbWrite(BASE + 32'h000, 32'h0, 4'hF, d);
    ee = 16'(32'hFFFF + d - w);
    nVec++;
    if (ioOut !== ee) begin
      nMiss++;
      $display("[TB] FAIL hold_disabled: got %h, want %h", ioOut, ee);
    end
    wbWrite(BASE + 32'h004, 32'h1234, 4'hF, ac);
    wbWrite(BASE + 32'h004, 32'hFFFF_FFAB, 4'b0001, ac);
    qExp.push_back(32'h0000_12AB);
    applyStimulus(BASE + 32'h004, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL byte0_write: got %h, want %h", rd, e);
    end
    wbWrite(BASE + 32'h004, 32'h0000_5600, 4'b0010, ac);
    nVec++;
    if (ioOut !== 16'h56AB) begin
      nMiss++;
      $display("[TB] FAIL byte1_write: got %h, want 56ab", ioOut);
    end
  endtask

  // LA freeze holds every channel; LA clear beats a same-cycle COUNT write.
  task automatic test_la();
    logic [31:0] rd, e;
    logic [15:0] f0, f1;
    logic ok;
    int ac, w0, w1;
    wbWrite(BASE + 32'h004, 32'd0, 4'hF, ac);
    wbWrite(BASE + 32'h014, 32'd0, 4'hF, ac);
    wbWrite(BASE + 32'h010, 32'h1, 4'hF, w1);
    wbWrite(BASE + 32'h000, 32'h1, 4'hF, w0);
    laOenb[64] = 1'b0;
    laDataIn[64] = 1'b1;
    f0 = 16'(cyc - w0);
    f1 = 16'(cyc - w1);
    for (int i = 0; i < 4; i++) begin
      nVec++;
      if (ioOut !== f0) begin
        nMiss++;
        $display("[TB] FAIL freeze_ch0[%0d]: got %h, want %h", i, ioOut, f0);
      end
      @(posedge clk); #1;
    end
    qExp.push_back({16'd0, f1});
    applyStimulus(BASE + 32'h014, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL freeze_ch1: got %h, want %h", rd, e);
    end
    laOenb[65] = 1'b0;
    laDataIn[65] = 1'b1;
    wbWrite(BASE + 32'h004, 32'd7, 4'hF, ac);
    nVec++;
    if (ioOut !== 16'd0) begin
      nMiss++;
      $display("[TB] FAIL clear_beats_write: got %h, want 0000", ioOut);
    end
    qExp.push_back(32'd0);
    applyStimulus(BASE + 32'h014, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL clear_ch1: got %h, want %h", rd, e);
    end
    laDataIn[65:64] = 2'b00;
    laOenb[65:64] = 2'b11;
    @(posedge clk); #1;
    nVec++;
    if (ioOut !== 16'd1) begin
      nMiss++;
      $display("[TB] FAIL resume_after_la: got %h, want 0001", ioOut);
    end
    wbWrite(BASE + 32'h000, 32'h0, 4'hF, ac);
    wbWrite(BASE + 32'h010, 32'h0, 4'hF, ac);
    wbWrite(BASE + 32'h100, 32'hF, 4'hF, ac);
  endtask

  // Request held across several edges: acks are single pulses, never adjacent.
  task automatic test_back_to_back();
    logic expAck;
    logic [31:0] expDat;
    wbs.wbs_adr_i = BASE + 32'h104;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      expAck = (k % 2 == 0);
      expDat = expAck ? ID_EXP : 32'd0;
      nVec++;
      if (wbs.wbs_ack_o !== expAck || wbs.wbs_dat_o !== expDat) begin
        nMiss++;
        $display("[TB] FAIL ack_pulse[%0d]: got ack=%b dat=%h, want ack=%b dat=%h", k, wbs.wbs_ack_o, wbs.wbs_dat_o, expAck, expDat);
      end
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reset asserted while counting and with an ack on the bus.
  task automatic test_reset_mid();
    logic [31:0] rd, e;
    logic ok;
    int ac;
    wbWrite(BASE + 32'h004, 32'd0, 4'hF, ac);
    wbWrite(BASE + 32'h000, 32'h1, 4'hF, ac);
    wbs.wbs_adr_i = BASE + 32'h104;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    nVec++;
    if (wbs.wbs_ack_o !== 1'b1) begin
      nMiss++;
      $display("[TB] FAIL pre_reset_ack: got %b, want 1", wbs.wbs_ack_o);
    end
    #2;
    rst = 1'b1;
    #1;
    nVec++;
    if (wbs.wbs_ack_o !== 1'b0 || wbs.wbs_dat_o !== 32'd0 || irq !== 3'd0 ||
        ioOeb !== 16'hFFFF || ioOut !== 16'd0 || laDataOut !== 128'd0) begin
      nMiss++;
      $display("[TB] FAIL async_reset: got ack=%b dat=%h irq=%b oeb=%h io=%h la=%h, want 0/0/0/ffff/0/0",
               wbs.wbs_ack_o, wbs.wbs_dat_o, irq, ioOeb, ioOut, laDataOut);
    end
    @(posedge clk); #1;
    nVec++;
    if (wbs.wbs_ack_o !== 1'b0) begin
      nMiss++;
      $display("[TB] FAIL ack_in_reset: got %b, want 0", wbs.wbs_ack_o);
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    qExp.push_back(32'd0);
    applyStimulus(BASE + 32'h000, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL ctrl_after_reset: got %h, want %h", rd, e);
    end
    qExp.push_back(32'h0000_FFFF);
    applyStimulus(BASE + 32'h008, 1'b0, 32'd0, 4'hF, rd, ok, ac);
    e = qExp.pop_front();
    nVec++;
    if (!ok || rd !== e) begin
      nMiss++;
      $display("[TB] FAIL cmp_after_reset: got %h, want %h", rd, e);
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_down_reload();
    test_wrap_and_bytes();
    test_la();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
